// File: rtl/pixel_filter_ctrl.sv
// Frame-synchronous pixel-filter controller: debounced mode button, frame-aligned
// mode commit and a 2-stage filter pipeline with matching sync/DE delay.
module pixel_filter_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic [7:0]  THRESH          = 8'h80,
  parameter logic        SYNC_ACTIVE     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_btn,
  input  logic [11:0] in_rgb,
  input  logic        in_de,
  input  logic        in_hsync,
  input  logic        in_vsync,
  output logic [11:0] out_rgb,
  output logic        out_de,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic [1:0]  mode,
  output logic        frame_start
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RGB_W  = 12;
  localparam int unsigned GRAY_W = 8;

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} db_state_t;

  db_state_t        db_state;
  logic [CNT_W-1:0] db_cnt;
  logic             btn_meta;
  logic             btn_sync;
  logic [1:0]       pending;
  logic             vsync_prev;

  logic [RGB_W-1:0]  s1_rgb;
  logic [GRAY_W-1:0] s1_gray;
  logic [1:0]        s1_mode;
  logic              s1_de;
  logic              s1_hsync;
  logic              s1_vsync;

  logic [GRAY_W-1:0] gray_c;
  logic [RGB_W-1:0]  s2_rgb;

  // Two-flop synchroniser for the asynchronous push-button
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= mode_btn;
      btn_sync <= btn_meta;
    end
  end

  // Debounce FSM; one pending increment per accepted press, none while held
  always_ff @(posedge clk) begin
    if (rst) begin
      db_state <= IDLE;
      db_cnt   <= '0;
      pending  <= 2'd0;
    end else begin
      case (db_state)
        IDLE: begin
          if (btn_sync) begin
            db_state <= PRESS;
            db_cnt   <= CNT_W'(1);
          end
        end
        PRESS: begin
          if (!btn_sync) begin
            db_state <= IDLE;
            db_cnt   <= '0;
          end else begin
            db_cnt <= db_cnt + CNT_W'(1);
            if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
              db_state <= HELD;
              pending  <= pending + 2'd1;
            end
          end
        end
        HELD: begin
          if (!btn_sync) begin
            db_state <= RELEASE;
            db_cnt   <= CNT_W'(1);
          end
        end
        RELEASE: begin
          if (btn_sync) begin
            db_state <= HELD;
            db_cnt   <= '0;
          end else begin
            db_cnt <= db_cnt + CNT_W'(1);
            if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
              db_state <= IDLE;
            end
          end
        end
        default: begin
          db_state <= IDLE;
          db_cnt   <= '0;
        end
      endcase
    end
  end

  // Frame-start detect on vsync entering its active level; commit pending mode there
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_prev  <= ~SYNC_ACTIVE;
      frame_start <= 1'b0;
      mode        <= 2'd0;
    end else begin
      vsync_prev  <= in_vsync;
      frame_start <= (in_vsync == SYNC_ACTIVE) && (vsync_prev != SYNC_ACTIVE);
      if (frame_start) begin
        mode <= pending;
      end
    end
  end

  // Luma approximation from 4-bit channels widened to 8 bits; max 230, no overflow
  always_comb begin
    gray_c = ({in_rgb[11:8], 4'h0} / 8'd3)
           + ({in_rgb[7:4],  4'h0} / 8'd2)
           + ({in_rgb[3:0],  4'h0} / 8'd8);
  end

  // Stage-2 filter select; blanking pixels are forced black
  always_comb begin
    s2_rgb = s1_rgb;
    case (s1_mode)
      2'd0: s2_rgb = s1_rgb;
      2'd1: s2_rgb = {3{s1_gray[7:4]}};
      2'd2: s2_rgb = ~s1_rgb;
      2'd3: s2_rgb = (s1_gray >= THRESH) ? 12'hFFF : 12'h000;
      default: s2_rgb = s1_rgb;
    endcase
    if (!s1_de) begin
      s2_rgb = 12'h000;
    end
  end

  // Two-stage pixel pipeline; mode is captured per pixel in stage 1
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_rgb    <= '0;
      s1_gray   <= '0;
      s1_mode   <= 2'd0;
      s1_de     <= 1'b0;
      s1_hsync  <= ~SYNC_ACTIVE;
      s1_vsync  <= ~SYNC_ACTIVE;
      out_rgb   <= '0;
      out_de    <= 1'b0;
      out_hsync <= ~SYNC_ACTIVE;
      out_vsync <= ~SYNC_ACTIVE;
    end else begin
      s1_rgb    <= in_rgb;
      s1_gray   <= gray_c;
      s1_mode   <= mode;
      s1_de     <= in_de;
      s1_hsync  <= in_hsync;
      s1_vsync  <= in_vsync;
      out_rgb   <= s2_rgb;
      out_de    <= s1_de;
      out_hsync <= s1_hsync;
      out_vsync <= s1_vsync;
    end
  end

endmodule
